// File: rtl/mult_div_unit_if.sv
// Operand/request and HI/LO/busy bundle between the E-stage and the multiply-divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input busy, HI, LO);
  modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// E-stage HI/LO multiply-divide unit: result is computed at launch and held until the
// countdown expires, so HI/LO only move on completion, MTHI/MTLO or reset.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  function automatic logic [63:0] mul_signed(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] ae, be, p;
    ae = a;
    be = b;
    p  = ae * be;
    return p;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be;
    ae = {32'd0, a};
    be = {32'd0, b};
    return ae * be;
  endfunction

  // Returns {remainder, quotient}; the most-negative / -1 case wraps to itself with zero remainder.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [31:0] q, r;
    if (b == 32'sd0) begin
      q = '0;
      r = '0;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      q = a;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (bus.op)
            3'd0, 3'd1: begin
              res_d   = (bus.op == 3'd0) ? mul_signed(bus.A, bus.B) : mul_unsigned(bus.A, bus.B);
              wr_d    = 1'b1;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = RUN;
            end
            3'd2, 3'd3: begin
              res_d   = (bus.op == 3'd2) ? div_signed(bus.A, bus.B) : div_unsigned(bus.A, bus.B);
              wr_d    = (bus.B != 32'd0);
              cnt_d   = 4'(DIV_CYCLES);
              state_d = RUN;
            end
            3'd4:    hi_d = bus.A;
            3'd5:    lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Requests while running are dropped; the stall controller should never send them.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, randomized ops against an arithmetic model,
// and hand-written sequences for requests during a run and reset mid-run.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [31:0] mhi, mlo;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output int n);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = 0;
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; n = MC; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; n = MC; end
      3'd2: begin
        n = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      3'd3: begin
        n = DC;
        if (b != 0) begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) % longint'({32'd0, b});
          lo = q[31:0]; hi = r[31:0];
        end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] h0, l0;
    int n;
    bit stable;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    h0 = bus.HI; l0 = bus.LO;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    n = 0; stable = 1'b1;
    while (bus.busy && n < 64) begin
      if (bus.HI !== h0 || bus.LO !== l0) stable = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    check({nm, " busy_cycles"}, 32'(n), 32'(exp_n));
    check({nm, " HI"}, bus.HI, exp_hi);
    check({nm, " LO"}, bus.LO, exp_lo);
    if (exp_n > 0) check({nm, " hilo_stable_midrun"}, {31'd0, stable}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rn;

    vecs.push_back('{"mthi",        3'd4, 32'h1234_5678, 32'h0,         0,  32'h1234_5678, 32'h0});
    vecs.push_back('{"mult_neg",    3'd0, 32'hFFFF_FFFE, 32'd3,         MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{"multu",       3'd1, 32'hFFFF_FFFE, 32'd3,         MC, 32'h0000_0002, 32'hFFFF_FFFA});
    vecs.push_back('{"div_neg",     3'd2, 32'hFFFF_FFF9, 32'd2,         DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_negdvr",  3'd2, 32'd7,         32'hFFFF_FFFE, DC, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{"div_bothneg", 3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, DC, 32'hFFFF_FFFF, 32'h0000_0003});
    vecs.push_back('{"divu",        3'd3, 32'd7,         32'd2,         DC, 32'h0000_0001, 32'h0000_0003});
    vecs.push_back('{"div_ovf",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"mthi_aa",     3'd4, 32'hAA,        32'h0,         0,  32'h0000_00AA, 32'h8000_0000});
    vecs.push_back('{"mtlo_bb",     3'd5, 32'hBB,        32'h0,         0,  32'h0000_00AA, 32'h0000_00BB});
    vecs.push_back('{"divu_by0",    3'd3, 32'd7,         32'd0,         DC, 32'h0000_00AA, 32'h0000_00BB});
    vecs.push_back('{"div_by0",     3'd2, 32'd9,         32'd0,         DC, 32'h0000_00AA, 32'h0000_00BB});
    vecs.push_back('{"noop6",       3'd6, 32'h1,         32'h1,         0,  32'h0000_00AA, 32'h0000_00BB});
    vecs.push_back('{"noop7",       3'd7, 32'h2,         32'h3,         0,  32'h0000_00AA, 32'h0000_00BB});

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.A = 32'h0; bus.B = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset HI", bus.HI, 32'd0);
    check("reset LO", bus.LO, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].hi, vecs[i].lo);
    end
    mhi = 32'hAA;
    mlo = 32'hBB;

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, mhi, mlo, rn);
      run_op($sformatf("rand%0d_op%0d", k, rop), rop, ra, rb, rn, mhi, mlo);
    end

    // Start request arriving mid-run must be ignored and the run completes normally.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("ignore busy_still_high", {31'd0, bus.busy}, 32'd1);
    check("ignore LO_untouched", bus.LO, mlo);
    begin
      int n;
      n = 0;
      while (bus.busy && n < 64) begin n++; @(posedge clk); #1; end
      check("ignore remaining_busy", 32'(n), 32'(DC - 3));
    end
    check("ignore HI", bus.HI, 32'd2);
    check("ignore LO", bus.LO, 32'd14);

    // Reset in the sixth busy cycle aborts the divide.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort busy_before_reset", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort HI", bus.HI, 32'd0);
    check("abort LO", bus.LO, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("abort late busy", {31'd0, bus.busy}, 32'd0);
    check("abort late HI", bus.HI, 32'd0);
    check("abort late LO", bus.LO, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
